// File: rtl/prog_sequencer.sv
// prog_sequencer: fetch/decode/execute controller for the 3-register-field
// datapath. It walks an 8-word instruction ROM (registered output, one-cycle
// latency) from address 0. It stops on a HALT word, on an illegal opcode, or
// after executing the last address. Every controller output is registered.
module prog_sequencer #(
    parameter int ADDR_W  = 3,
    parameter int INSTR_W = 25,
    parameter int IMM_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_en,
    output logic [2:0]         rf_raddr_a,
    output logic [2:0]         rf_raddr_b,
    output logic [2:0]         rf_waddr,
    output logic               rf_we,
    output logic               wdata_sel,
    output logic [1:0]         alu_op,
    output logic [IMM_W-1:0]   imm_out,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // Instruction field positions, counted down from the top of the word.
    localparam int OPC_LSB = INSTR_W - 3;
    localparam int RD_LSB  = INSTR_W - 6;
    localparam int RS_LSB  = INSTR_W - 9;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;

    localparam logic [1:0] ALU_PASS_B = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_XOR    = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DECODE,
        EXEC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    logic               romEn_q, romEn_d;
    logic               rfWe_q, rfWe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [2:0]         raddrA_q, raddrA_d;
    logic [2:0]         raddrB_q, raddrB_d;
    logic [2:0]         waddr_q, waddr_d;
    logic               wdataSel_q, wdataSel_d;
    logic [1:0]         aluOp_q, aluOp_d;
    logic [IMM_W-1:0]   imm_q, imm_d;

    // Fields of the word that IR holds next cycle. The decode outputs are
    // loaded at the same edge as IR, so they are valid in the DECODE cycle.
    logic [2:0]         nextOpcode;
    logic [2:0]         nextRd;
    logic [2:0]         nextRs;
    logic [IMM_W-1:0]   nextImm;

    assign nextOpcode = ir_d[INSTR_W-1:OPC_LSB];
    assign nextRd     = ir_d[RD_LSB+2:RD_LSB];
    assign nextRs     = ir_d[RS_LSB+2:RS_LSB];
    assign nextImm    = ir_d[IMM_W-1:0];

    // ALU operation implied by an opcode. LOAD and illegal codes use PASS_B.
    function automatic logic [1:0] aluOpFor(input logic [2:0] opcode);
        case (opcode)
            OP_MOV:  return ALU_PASS_B;
            OP_ADD:  return ALU_ADD;
            OP_XOR:  return ALU_XOR;
            default: return ALU_PASS_B;
        endcase
    endfunction

    // Next-state logic. Output registers are computed from the state being
    // entered, so each output is aligned with its state without extra delay.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        err_d      = err_q;
        raddrA_d   = raddrA_q;
        raddrB_d   = raddrB_q;
        waddr_d    = waddr_q;
        wdataSel_d = wdataSel_q;
        aluOp_d    = aluOp_q;
        imm_d      = imm_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                ir_d    = instr_in;
                state_d = DECODE;
            end
            DECODE: begin
                if (ir_q == '0) begin
                    state_d = DONE;
                end else if (ir_q[INSTR_W-1]) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (pc_q == '1) begin
                    state_d = DONE;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        romEn_d = (state_d == FETCH) || (state_d == WAIT);
        rfWe_d  = (state_d == EXEC);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE) && !err_d;

        if ((state_d == IDLE) || (state_d == FETCH)) begin
            raddrA_d   = 3'd0;
            raddrB_d   = 3'd0;
            waddr_d    = 3'd0;
            wdataSel_d = 1'b0;
            aluOp_d    = 2'b00;
            imm_d      = '0;
        end else if (state_d == DECODE) begin
            raddrA_d   = nextRd;
            raddrB_d   = nextRs;
            waddr_d    = nextRd;
            wdataSel_d = (nextOpcode == OP_LOAD);
            aluOp_d    = aluOpFor(nextOpcode);
            imm_d      = nextImm;
        end
    end

    // State, PC, IR and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            romEn_q    <= 1'b0;
            rfWe_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            raddrA_q   <= 3'd0;
            raddrB_q   <= 3'd0;
            waddr_q    <= 3'd0;
            wdataSel_q <= 1'b0;
            aluOp_q    <= 2'b00;
            imm_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            romEn_q    <= romEn_d;
            rfWe_q     <= rfWe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            raddrA_q   <= raddrA_d;
            raddrB_q   <= raddrB_d;
            waddr_q    <= waddr_d;
            wdataSel_q <= wdataSel_d;
            aluOp_q    <= aluOp_d;
            imm_q      <= imm_d;
        end
    end

    assign rom_addr   = pc_q;
    assign rom_en     = romEn_q;
    assign rf_raddr_a = raddrA_q;
    assign rf_raddr_b = raddrB_q;
    assign rf_waddr   = waddr_q;
    assign rf_we      = rfWe_q;
    assign wdata_sel  = wdataSel_q;
    assign alu_op     = aluOp_q;
    assign imm_out    = imm_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: drives prog_sequencer with directed and random programs.
// A timeline model built from the program contents predicts every output on
// every cycle. Literal expectations from hand-worked programs pin that model.
module tb_prog_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [24:0] instr_in;
    logic [2:0]  rom_addr;
    logic        rom_en;
    logic [2:0]  rf_raddr_a;
    logic [2:0]  rf_raddr_b;
    logic [2:0]  rf_waddr;
    logic        rf_we;
    logic        wdata_sel;
    logic [1:0]  alu_op;
    logic [15:0] imm_out;
    logic        busy;
    logic        done;
    logic        err;

    prog_sequencer #(.ADDR_W(3), .INSTR_W(25), .IMM_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .instr_in(instr_in),
        .rom_addr(rom_addr), .rom_en(rom_en),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .wdata_sel(wdata_sel), .alu_op(alu_op), .imm_out(imm_out),
        .busy(busy), .done(done), .err(err)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction ROM: registered read, one-cycle latency.
    logic [24:0] romMem [0:7];
    always @(posedge clk) begin
        if (rom_en) instr_in <= romMem[rom_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural timeline model ----------------
    int          cycleCnt = 0;
    bit          modelValid = 0;
    bit          runActive = 0;
    int          runOffset = 0;
    int          doneOff = 0;
    int          finalPc = 0;
    bit          runErr = 0;
    logic [2:0]  idleAddr = 3'd0;
    bit          idleErr = 0;
    int          startEdgeCyc = 0;

    logic        eRomEn  [0:40];
    logic [2:0]  eAddr   [0:40];
    logic        eWe     [0:40];
    logic        eBusy   [0:40];
    logic        eDone   [0:40];
    logic        eErr    [0:40];
    logic [2:0]  eRd     [0:40];
    logic [2:0]  eRs     [0:40];
    logic [15:0] eImm    [0:40];
    logic        eSel    [0:40];
    logic [1:0]  eAlu    [0:40];
    bit          eChkSel [0:40];
    bit          eChkAlu [0:40];

    // Cycle k after the start edge belongs to word (k-1)/4 in phase (k-1)%4:
    // fetch, wait, decode, execute. A HALT or illegal word uses its fourth
    // slot as the DONE cycle; running past word 7 puts DONE at slot 33.
    function automatic void buildTimeline();
        logic [24:0] w;
        logic [2:0]  op;
        int          idx;
        bit          ended;
        for (int j = 0; j <= 40; j++) begin
            eRomEn[j] = 0; eAddr[j] = 0; eWe[j] = 0; eBusy[j] = 0; eDone[j] = 0;
            eErr[j] = 0; eRd[j] = 0; eRs[j] = 0; eImm[j] = 0; eSel[j] = 0;
            eAlu[j] = 0; eChkSel[j] = 1; eChkAlu[j] = 1;
        end
        ended = 0;
        doneOff = 33;
        finalPc = 7;
        runErr = 0;
        for (int i = 0; i < 8; i++) begin
            if (!ended) begin
                w = romMem[i];
                op = w[24:22];
                for (int p = 1; p <= 4; p++) begin
                    idx = 4 * i + p;
                    eAddr[idx] = 3'(i);
                    eBusy[idx] = 1;
                    if (p <= 2) begin
                        eRomEn[idx] = 1;
                    end else begin
                        eRd[idx] = w[21:19];
                        eRs[idx] = w[18:16];
                        eImm[idx] = w[15:0];
                        eChkAlu[idx] = (op >= 3'd1) && (op <= 3'd3);
                        eAlu[idx] = (op == 3'd2) ? 2'd1 : (op == 3'd3) ? 2'd2 : 2'd0;
                        eChkSel[idx] = (op <= 3'd3) && (w != 25'd0);
                        eSel[idx] = (op == 3'd0);
                    end
                end
                if (w == 25'd0 || op[2]) begin
                    ended = 1;
                    doneOff = 4 * i + 4;
                    finalPc = i;
                    runErr = op[2];
                end else begin
                    eWe[4 * i + 4] = 1;
                end
            end
        end
        if (doneOff == 33) begin
            eRd[33] = eRd[32]; eRs[33] = eRs[32]; eImm[33] = eImm[32];
            eSel[33] = eSel[32]; eAlu[33] = eAlu[32];
            eChkSel[33] = eChkSel[32]; eChkAlu[33] = eChkAlu[32];
        end
        eWe[doneOff] = 0;
        eRomEn[doneOff] = 0;
        eBusy[doneOff] = 1;
        eAddr[doneOff] = 3'(finalPc);
        eDone[doneOff] = !runErr;
        eErr[doneOff] = runErr;
    endfunction

    // Model advance on each rising edge, driven only by rst/start and the ROM.
    always @(posedge clk) begin
        cycleCnt++;
        if (rst) begin
            modelValid = 1;
            runActive = 0;
            idleAddr = 3'd0;
            idleErr = 0;
        end else if (modelValid) begin
            if (runActive) begin
                runOffset++;
                if (runOffset > doneOff) begin
                    runActive = 0;
                    idleAddr = 3'(finalPc);
                    idleErr = runErr;
                end
            end else if (start) begin
                buildTimeline();
                runActive = 1;
                runOffset = 1;
                startEdgeCyc = cycleCnt;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (modelValid) begin
            if (runActive) begin
                checkOutput("rom_en", 32'(rom_en), 32'(eRomEn[runOffset]));
                checkOutput("rom_addr", 32'(rom_addr), 32'(eAddr[runOffset]));
                checkOutput("rf_we", 32'(rf_we), 32'(eWe[runOffset]));
                checkOutput("busy", 32'(busy), 32'(eBusy[runOffset]));
                checkOutput("done", 32'(done), 32'(eDone[runOffset]));
                checkOutput("err", 32'(err), 32'(eErr[runOffset]));
                checkOutput("rf_raddr_a", 32'(rf_raddr_a), 32'(eRd[runOffset]));
                checkOutput("rf_waddr", 32'(rf_waddr), 32'(eRd[runOffset]));
                checkOutput("rf_raddr_b", 32'(rf_raddr_b), 32'(eRs[runOffset]));
                checkOutput("imm_out", 32'(imm_out), 32'(eImm[runOffset]));
                if (eChkSel[runOffset]) checkOutput("wdata_sel", 32'(wdata_sel), 32'(eSel[runOffset]));
                if (eChkAlu[runOffset]) checkOutput("alu_op", 32'(alu_op), 32'(eAlu[runOffset]));
            end else begin
                checkOutput("idle_rom_en", 32'(rom_en), 32'd0);
                checkOutput("idle_rom_addr", 32'(rom_addr), 32'(idleAddr));
                checkOutput("idle_rf_we", 32'(rf_we), 32'd0);
                checkOutput("idle_busy", 32'(busy), 32'd0);
                checkOutput("idle_done", 32'(done), 32'd0);
                checkOutput("idle_err", 32'(err), 32'(idleErr));
                checkOutput("idle_decode", {8'd0, imm_out, rf_raddr_a, rf_raddr_b, rf_waddr, wdata_sel, alu_op}, 32'd0);
            end
        end
    end

    // ---------------- observation recorder for literal checks ----------------
    logic [2:0] weWaddrQ[$];
    logic       weSelQ[$];
    logic [1:0] weAluQ[$];
    logic [2:0] maxAddr = 3'd0;
    logic [2:0] lastFetchAddr = 3'd0;
    int         fetch0Cnt = 0;
    int         doneCnt = 0;
    int         doneCyc = 0;
    bit         doneSeen = 0;
    logic       prevRomEn = 1'b0;

    // Records write strobes, fetches and done pulses for per-test checks.
    always @(negedge clk) begin
        if (rf_we) begin
            weWaddrQ.push_back(rf_waddr);
            weSelQ.push_back(wdata_sel);
            weAluQ.push_back(alu_op);
        end
        if (busy && rom_addr > maxAddr) maxAddr = rom_addr;
        if (rom_en && !prevRomEn) begin
            lastFetchAddr = rom_addr;
            if (rom_addr == 3'd0) fetch0Cnt++;
        end
        if (done) begin
            doneCnt++;
            if (!doneSeen) begin
                doneSeen = 1;
                doneCyc = cycleCnt;
            end
        end
        prevRomEn = rom_en;
    end

    task automatic clearRecord();
        weWaddrQ.delete();
        weSelQ.delete();
        weAluQ.delete();
        maxAddr = 3'd0;
        lastFetchAddr = 3'd0;
        fetch0Cnt = 0;
        doneCnt = 0;
        doneSeen = 0;
    endtask

    // Sets start/rst, then lets nCycles rising edges pass (inputs change 2 units after an edge).
    task automatic applyStimulus(input logic startVal, input logic rstVal, input int nCycles);
        start = startVal;
        rst = rstVal;
        repeat (nCycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic waitRunEnd(input int maxCycles);
        int n;
        n = 0;
        while ((busy || runActive) && n < maxCycles) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("run_end_busy", 32'(busy), 32'd0);
    endtask

    function automatic logic [24:0] mkInstr(input logic [2:0] op, input logic [2:0] rd,
                                            input logic [2:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [24:0] randWord();
        int r;
        logic [2:0] op;
        r = $urandom_range(0, 15);
        if (r == 0) return 25'd0;
        if (r == 1) op = 3'($urandom_range(4, 7));
        else op = 3'($urandom_range(0, 3));
        return {op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom)};
    endfunction

    task automatic loadRef();
        romMem[0] = mkInstr(3'b000, 3'd2, 3'd0, 16'd1);
        romMem[1] = mkInstr(3'b000, 3'd1, 3'd0, 16'd1);
        romMem[2] = mkInstr(3'b010, 3'd2, 3'd1, 16'd0);
        romMem[3] = mkInstr(3'b011, 3'd2, 3'd1, 16'd0);
        romMem[4] = mkInstr(3'b001, 3'd7, 3'd1, 16'd0);
        romMem[5] = 25'd0;
        romMem[6] = 25'd0;
        romMem[7] = 25'd0;
    endtask

    task automatic loadFull();
        for (int i = 0; i < 8; i++) romMem[i] = mkInstr(3'b001, 3'd1, 3'd1, 16'd0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) romMem[i] = 25'd0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rom_en", 32'(rom_en), 32'd0);
        checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
        checkOutput("reset_done_err", {30'd0, done, err}, 32'd0);
        rst = 1'b0;
        applyStimulus(0, 0, 2);

        $display("[TB] reference program");
        loadRef();
        clearRecord();
        applyStimulus(1, 0, 1);
        checkOutput("model_ref_doneoff", 32'(doneOff), 32'd24);
        applyStimulus(0, 0, 0);
        waitRunEnd(100);
        checkOutput("ref_we_count", 32'(weWaddrQ.size()), 32'd5);
        checkOutput("ref_waddr0", 32'(weWaddrQ[0]), 32'd2);
        checkOutput("ref_waddr1", 32'(weWaddrQ[1]), 32'd1);
        checkOutput("ref_waddr2", 32'(weWaddrQ[2]), 32'd2);
        checkOutput("ref_waddr3", 32'(weWaddrQ[3]), 32'd2);
        checkOutput("ref_waddr4", 32'(weWaddrQ[4]), 32'd7);
        checkOutput("ref_sel", {27'd0, weSelQ[0], weSelQ[1], weSelQ[2], weSelQ[3], weSelQ[4]}, 32'b11000);
        checkOutput("ref_alu2", 32'(weAluQ[2]), 32'd1);
        checkOutput("ref_alu3", 32'(weAluQ[3]), 32'd2);
        checkOutput("ref_alu4", 32'(weAluQ[4]), 32'd0);
        checkOutput("ref_halt_fetch_addr", 32'(lastFetchAddr), 32'd5);
        checkOutput("ref_done_latency", 32'(doneCyc - startEdgeCyc), 32'd23);
        checkOutput("ref_done_count", 32'(doneCnt), 32'd1);
        checkOutput("ref_err", 32'(err), 32'd0);
        checkOutput("ref_max_addr", 32'(maxAddr), 32'd5);

        $display("[TB] full program");
        loadFull();
        clearRecord();
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 0);
        waitRunEnd(100);
        checkOutput("full_we_count", 32'(weWaddrQ.size()), 32'd8);
        checkOutput("full_max_addr", 32'(maxAddr), 32'd7);
        checkOutput("full_fetch0", 32'(fetch0Cnt), 32'd1);
        checkOutput("full_done_latency", 32'(doneCyc - startEdgeCyc), 32'd32);
        checkOutput("full_idle_addr", 32'(rom_addr), 32'd7);

        $display("[TB] illegal opcode");
        romMem[0] = mkInstr(3'b000, 3'd1, 3'd0, 16'd5);
        romMem[1] = mkInstr(3'b001, 3'd2, 3'd1, 16'd0);
        romMem[2] = mkInstr(3'b101, 3'd3, 3'd2, 16'd9);
        clearRecord();
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 0);
        waitRunEnd(100);
        checkOutput("ill_we_count", 32'(weWaddrQ.size()), 32'd2);
        checkOutput("ill_done_count", 32'(doneCnt), 32'd0);
        checkOutput("ill_err", 32'(err), 32'd1);
        checkOutput("ill_last_fetch", 32'(lastFetchAddr), 32'd2);
        applyStimulus(1, 0, 1);
        checkOutput("ill_err_cleared", 32'(err), 32'd0);
        applyStimulus(0, 0, 0);
        waitRunEnd(100);

        $display("[TB] reset mid-run");
        loadFull();
        clearRecord();
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 15);
        checkOutput("mid_exec_we", 32'(rf_we), 32'd1);
        checkOutput("mid_exec_addr", 32'(rom_addr), 32'd3);
        applyStimulus(0, 1, 1);
        checkOutput("mid_rst_we", 32'(rf_we), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_addr", 32'(rom_addr), 32'd0);
        applyStimulus(0, 0, 2);
        clearRecord();
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 0);
        waitRunEnd(100);
        checkOutput("mid_rerun_we", 32'(weWaddrQ.size()), 32'd8);
        checkOutput("mid_rerun_fetch0", 32'(fetch0Cnt), 32'd1);

        $display("[TB] start held through DONE");
        loadRef();
        clearRecord();
        applyStimulus(1, 0, 26);
        applyStimulus(0, 0, 0);
        waitRunEnd(100);
        checkOutput("hold_fetch0", 32'(fetch0Cnt), 32'd2);
        checkOutput("hold_done_count", 32'(doneCnt), 32'd2);
        checkOutput("hold_we_count", 32'(weWaddrQ.size()), 32'd10);

        $display("[TB] start pulse in WAIT");
        clearRecord();
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 0);
        waitRunEnd(100);
        checkOutput("pulse_fetch0", 32'(fetch0Cnt), 32'd1);
        checkOutput("pulse_done_count", 32'(doneCnt), 32'd1);

        $display("[TB] random programs");
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < 8; i++) romMem[i] = randWord();
            applyStimulus(1, 0, $urandom_range(1, 3));
            start = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(0, 0, $urandom_range(1, 30));
                applyStimulus(0, 1, 1);
                rst = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
                applyStimulus(0, 0, $urandom_range(1, 12));
                applyStimulus(1, 0, 1);
                start = 1'b0;
            end
            waitRunEnd(100);
            applyStimulus(0, 0, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Fetch/decode/execute controller for the 3-register-field datapath.
- Reads 25-bit instruction words from the 8-entry instruction ROM, which has registered output and one-cycle latency.
- Drives register-file read and write addresses, write enable, write-data select and ALU op.
- Runs a program from address 0 until it fetches a HALT word or finishes executing address 7.

Parameters:
- ADDR_W, 3, ROM address width; program length is 2**ADDR_W words.
- INSTR_W, 25, instruction width; fields are opcode[24:22], rd[21:19], rs[18:16], imm[15:0].
- IMM_W, 16, immediate width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin program at address 0; sampled only in IDLE.
- instr_in  in  25  ROM data_out.
- rom_addr  out  3  ROM address (equals PC).
- rom_en  out  1  ROM enable.
- rf_raddr_a  out  3  read port A address (= rd).
- rf_raddr_b  out  3  read port B address (= rs).
- rf_waddr  out  3  write address (= rd).
- rf_we  out  1  register-file write strobe, one cycle per instruction.
- wdata_sel  out  1  write-data select: 0 = ALU result, 1 = immediate.
- alu_op  out  2  ALU operation: 00 = PASS_B, 01 = ADD, 10 = XOR, 11 = reserved.
- imm_out  out  16  immediate field of the current instruction.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal program completion.
- err  out  1  illegal opcode seen; sticky.

Behaviour:
- Reset (rst=1 at a clock edge) forces, from any state including mid-instruction:
  - state = IDLE, PC = 0, IR = 0;
  - all outputs 0, including err.
- States and transitions:
  - IDLE: start=1 → FETCH; clears err.
  - FETCH: rom_en=1, rom_addr=PC → WAIT.
  - WAIT: rom_en=1, address held; instr_in is valid this cycle and is latched into IR at the end of the cycle → DECODE.
  - DECODE: drives rf_raddr_a/b, rf_waddr, alu_op, wdata_sel and imm_out from IR.
    - IR == 0 (HALT) → DONE.
    - opcode ≥ 100 → DONE with err set.
    - otherwise → EXEC.
  - EXEC: rf_we=1 for exactly this cycle, decode outputs held. If PC == 7 → DONE; else PC increments → FETCH.
  - DONE: done=1 for one cycle (0 when err is set) → IDLE. PC is left at its final value.
- Latency: 4 cycles per executed instruction; the HALT word costs 3 cycles plus the DONE cycle.
- Decode rules:
  - 000 LOAD: wdata_sel=1, rd ← imm.
  - 001 MOV: alu_op=00, rd ← rs.
  - 010 ADD: alu_op=01, rd ← rd + rs.
  - 011 XOR: alu_op=10, rd ← rd ^ rs.
- HALT is the all-zero word only. LOAD r0 with imm 0 is therefore not executable.
- The PC never wraps. Completion after address 7 goes to DONE, and rom_addr never returns to 0 within one run.
- start is ignored while busy. start held high through DONE restarts in the following IDLE cycle.
- rf_we is never asserted in DECODE, DONE, or for a HALT or illegal word.
- Writes to r0 are permitted.
- Decode outputs are 0 in IDLE and FETCH and hold their last value otherwise.

Test Plan:
- Reference program:
  - ROM = {LOAD r2 1, LOAD r1 1, ADD r2 r1, XOR r2 r1, MOV r7 r1, 0, 0, 0}; pulse start.
  - Required: exactly 5 rf_we pulses; rf_waddr sequence 2,1,2,2,7; wdata_sel 1,1,0,0,0; alu_op –,–,01,10,00.
  - Required: HALT fetched at address 5; done pulses 23 cycles after the start-sample edge; err=0; rom_addr never exceeds 5.
- Full program: 8 non-HALT words (MOV r1 r1 ×8) → 8 rf_we pulses, rom_addr 0..7, done after the 8th EXEC, no second fetch at address 0.
- Illegal opcode: word 2 = opcode 101 → 2 rf_we pulses, err=1 after word 2's DECODE, done stays 0, busy=0 afterwards; next start clears err.
- Reset mid-run: assert rst during EXEC of word 3 → next cycle rf_we=0, busy=0, rom_addr=0; a later start re-runs from address 0.
- start handling: start held high for the whole run and start pulsed during WAIT → no extra restart mid-run; exactly one restart occurs after DONE while start is still high.
